uart_rx_fifo_m: RTL and testbench
=================================

UART_RX_FIFO_M -- requirements
Module: uart_rx_fifo_m

Interface
REQ-001 Parameter RXINVERT, default 1'b1; when 1, rxpin is logically inverted before use (pad inversion not present), so the line idles low at rxpin.
REQ-002 Parameter STOPCHECK, default 1'b1; when 1, a low stop-bit sample is a framing error; when 0, the stop bit is not checked.
REQ-003 clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 resetn  input  1  reset, synchronous and active-low.
REQ-005 bitx8ce  input  1  clock enable at 8x bit rate, one clk wide; shared with the transmitter's baud generator.
REQ-006 rxpin  input  1  serial input, asynchronous to clk.
REQ-007 rd  input  1  pop request; honoured only when rxvalid=1.
REQ-008 clrerr  input  1  clears ferr and ovf.
REQ-009 q  output  8  byte at FIFO head; don't-care when rxvalid=0.
REQ-010 rxvalid  output  1  FIFO not empty.
REQ-011 ferr  output  1  sticky framing error.
REQ-012 ovf  output  1  sticky overrun.

Function
REQ-013 rxpin shall pass through a 2-flop synchronizer (initialised to idle level) before RXINVERT correction; synchronized line is "rxl", idle 1.
REQ-014 FSM states IDLE, START, DATA, STOP, BREAK; all transitions and tick counting occur only on clk edges with bitx8ce=1.
REQ-015 IDLE: rxl=0 -> START, tick counter (3 bits) := 0.
REQ-016 Each bit period is 8 ticks; bit value = majority of rxl at ticks 3,4,5.
REQ-017 START: at tick 5, majority 1 -> IDLE (glitch rejected, no byte, no error); majority 0 -> DATA with bit index 0 after tick 7.
REQ-018 DATA: 8 bits, LSB first, shifted into an 8-bit shift register; after bit 7 tick 7 -> STOP.
REQ-019 STOP: at tick 5, majority 1 or STOPCHECK=0 -> push byte, -> IDLE; majority 0 with STOPCHECK=1 -> ferr:=1, byte discarded, -> BREAK.
REQ-020 BREAK: remain until rxl=1 on a bitx8ce tick, then -> IDLE.
REQ-021 Push shall make the byte visible on q/rxvalid on the clk edge following the tick-5 stop sample (latency 1 clk).
REQ-022 FIFO: 2 entries, head on q; rd with rxvalid=1 pops on that edge.
REQ-023 Push with FIFO full and no pop: byte dropped, ovf:=1, existing entries unchanged.
REQ-024 Push and pop on the same edge: both performed; when full, no overrun and occupancy remains 2.
REQ-025 rd with rxvalid=0: ignored.
REQ-026 clrerr=1 clears ferr and ovf; an error event on the same edge wins (flag set).
REQ-027 FIFO read/write pointers wrap modulo 2; occupancy counter range 0..2.

Reset
REQ-028 resetn=0 on a clk edge: FSM -> IDLE, tick/bit counters 0, FIFO empty (rxvalid=0), ferr=0, ovf=0, synchronizer flops to idle, q=8'h00.
REQ-029 Reset mid-frame abandons the frame; no partial byte is pushed; a reception may start from the next falling edge after resetn=1.

Structure
REQ-030 FSM state encodings and the constants 8 (ticks/bit), 5 (sample-decision tick) shall live in the shared uart package, used also by the transmitter.
REQ-031 The 2-entry FIFO shall be a sub-module named uart_fifo2_m (data 8, push, pop, full, empty).
REQ-032 No vendor primitives; pure inferred logic, intended for iCE40.

Verification
REQ-033 Loopback from the team transmitter (rxpin = ~txpin, RXINVERT=1), send 8'h41 then 8'h4E, rd asserted on rxvalid -> q=8'h41 then 8'h4E, ferr=0, ovf=0.
REQ-034 Drive line low for 2 bitx8ce ticks then idle -> no rxvalid, no ferr, FSM back to IDLE.
REQ-035 Send 8'h55 with stop bit forced 0 for 8 ticks -> ferr=1, rxvalid stays 0; subsequent 8'hA5 with good stop received correctly after line returns idle.
REQ-036 Send 8'h41, 8'h4E, 8'h33 with rd=0 -> q=8'h41, after pop 8'h4E, ovf=1; 8'h33 never appears; clrerr -> ovf=0.
REQ-037 FIFO full, pop asserted on the push edge of a third byte 8'h33 -> ovf=0, sequence 8'h4E then 8'h33.
REQ-038 Assert resetn=0 during data bit 4 of 8'hC3, release, then send 8'h3C -> only 8'h3C received, no error flags.

Source files
------------

// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared UART definitions used by both the receiver and the transmitter:
// the receive FSM state encoding, the oversampling constants and a small
// majority-vote helper.
// ---------------------------------------------------------------------------
package uart_pkg;

   // Receiver state machine states
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
      STOP  = 3'd3,
      BREAK = 3'd4
   } uartState_t;

   // Oversampling: one bit period is this many bitx8ce ticks
   localparam int TICKS_PER_BIT = 8;

   // Tick on which the bit decision is made (majority of ticks 3,4,5)
   localparam logic [2:0] SAMPLE_TICK = 3'd5;

   // Derived tick positions used by the receiver
   localparam logic [2:0] FIRST_SAMPLE_TICK = SAMPLE_TICK - 3'd2;
   localparam logic [2:0] MID_SAMPLE_TICK   = SAMPLE_TICK - 3'd1;
   localparam logic [2:0] LAST_TICK         = 3'(TICKS_PER_BIT - 1);

   // Two-out-of-three vote used to reject single-tick noise on the line
   function automatic logic majority3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/uart_fifo2_m.sv
// ---------------------------------------------------------------------------
// uart_fifo2_m
// Two-entry FIFO holding received bytes. The head entry is always visible
// on rdata. A pop on an empty FIFO is ignored; a push on a full FIFO is
// accepted only when a pop happens on the same edge.
//
// Ports
//   clk     system clock
//   resetn  synchronous active-low reset (empties the FIFO, clears storage)
//   wdata   byte to write
//   push    write request
//   pop     read request (ignored when empty)
//   rdata   byte at the FIFO head
//   full    two entries held
//   empty   no entries held
// ---------------------------------------------------------------------------
module uart_fifo2_m
   import uart_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic [WIDTH-1:0] wdata,
   input  logic             push,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   logic [WIDTH-1:0] mem [2];
   logic             wrPtr;
   logic             rdPtr;
   logic [1:0]       count;
   logic             doPush;
   logic             doPop;

   assign empty = (count == 2'd0);
   assign full  = (count == 2'd2);
   assign rdata = mem[rdPtr];

   // Qualify the requests. When full, a simultaneous pop frees the slot the
   // write pointer points at, so the push can still be accepted.
   always_comb begin
      doPop  = pop & ~empty;
      doPush = push & (~full | doPop);
   end

   // Storage, one-bit pointers that wrap naturally, and the occupancy count.
   // A simultaneous push and pop leaves the count unchanged.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         for (int i = 0; i < 2; i++) begin
            mem[i] <= '0;
         end
         wrPtr <= 1'b0;
         rdPtr <= 1'b0;
         count <= 2'd0;
      end else begin
         if (doPush) begin
            mem[wrPtr] <= wdata;
            wrPtr      <= ~wrPtr;
         end
         if (doPop) begin
            rdPtr <= ~rdPtr;
         end
         case ({doPush, doPop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/uart_rx_fifo_m.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo_m
// 8N1 UART receiver with 8x oversampling and a two-entry receive FIFO.
// The serial line is synchronised, optionally inverted, then decoded by a
// small FSM that votes each bit over ticks 3,4,5 of its bit period.
//
// Ports
//   clk      system clock
//   resetn   synchronous active-low reset
//   bitx8ce  one-clk enable at 8x the bit rate
//   rxpin    asynchronous serial input
//   rd       pop request (honoured only when rxvalid=1)
//   clrerr   clears the sticky error flags
//   q        byte at FIFO head
//   rxvalid  FIFO not empty
//   ferr     sticky framing error
//   ovf      sticky overrun (byte dropped because the FIFO was full)
// ---------------------------------------------------------------------------
module uart_rx_fifo_m
   import uart_pkg::*;
#(
   parameter logic RXINVERT  = 1'b1,
   parameter logic STOPCHECK = 1'b1
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       bitx8ce,
   input  logic       rxpin,
   input  logic       rd,
   input  logic       clrerr,
   output logic [7:0] q,
   output logic       rxvalid,
   output logic       ferr,
   output logic       ovf
);

   // Idle level as seen at the pin, before inversion
   localparam logic PIN_IDLE = ~RXINVERT;

   logic       syncA;
   logic       syncB;
   logic       rxl;

   uartState_t state;
   uartState_t stateNext;
   logic [2:0] tick;
   logic [2:0] tickNext;
   logic [2:0] bitIdx;
   logic [2:0] bitIdxNext;
   logic [7:0] shiftReg;
   logic [7:0] shiftNext;
   logic       samp3;
   logic       samp3Next;
   logic       samp4;
   logic       samp4Next;
   logic       bitVote;
   logic       pushNow;
   logic       pushPend;
   logic       frameErr;
   logic       fifoFull;
   logic       fifoEmpty;
   logic       ovfEvent;

   // Two-flop synchroniser for the asynchronous pin. Both flops start at
   // the idle level so that reset never looks like a start bit.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         syncA <= PIN_IDLE;
         syncB <= PIN_IDLE;
      end else begin
         syncA <= rxpin;
         syncB <= syncA;
      end
   end

   // Logical line level, idle high regardless of pad polarity
   assign rxl = syncB ^ RXINVERT;

   // Next-state logic. Everything advances only on bitx8ce. Ticks 3 and 4
   // are captured into samp3/samp4; at tick 5 the live line value completes
   // the vote. The tick counter is 3 bits so it wraps from 7 to 0 at the
   // end of each bit period on its own.
   always_comb begin
      stateNext  = state;
      tickNext   = tick;
      bitIdxNext = bitIdx;
      shiftNext  = shiftReg;
      samp3Next  = samp3;
      samp4Next  = samp4;
      pushNow    = 1'b0;
      frameErr   = 1'b0;
      bitVote    = majority3(samp3, samp4, rxl);

      if (bitx8ce) begin
         if (state inside {START, DATA, STOP}) begin
            tickNext = tick + 3'd1;
            if (tick == FIRST_SAMPLE_TICK) begin
               samp3Next = rxl;
            end
            if (tick == MID_SAMPLE_TICK) begin
               samp4Next = rxl;
            end
         end

         case (state)
            IDLE: begin
               if (!rxl) begin
                  stateNext = START;
                  tickNext  = 3'd0;
               end
            end
            START: begin
               if (tick == SAMPLE_TICK && bitVote) begin
                  stateNext = IDLE;
               end else if (tick == LAST_TICK) begin
                  stateNext  = DATA;
                  bitIdxNext = 3'd0;
               end
            end
            DATA: begin
               if (tick == SAMPLE_TICK) begin
                  shiftNext = {bitVote, shiftReg[7:1]};
               end
               if (tick == LAST_TICK) begin
                  if (bitIdx == 3'd7) begin
                     stateNext = STOP;
                  end else begin
                     bitIdxNext = bitIdx + 3'd1;
                  end
               end
            end
            STOP: begin
               if (tick == SAMPLE_TICK) begin
                  if (bitVote || !STOPCHECK) begin
                     pushNow   = 1'b1;
                     stateNext = IDLE;
                  end else begin
                     frameErr  = 1'b1;
                     stateNext = BREAK;
                  end
               end
            end
            BREAK: begin
               if (rxl) begin
                  stateNext = IDLE;
               end
            end
            default: stateNext = IDLE;
         endcase
      end
   end

   // FSM registers. The push request is registered so the byte reaches the
   // FIFO one clock after the stop-bit decision; shiftReg is stable then.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state    <= IDLE;
         tick     <= 3'd0;
         bitIdx   <= 3'd0;
         shiftReg <= 8'h00;
         samp3    <= 1'b1;
         samp4    <= 1'b1;
         pushPend <= 1'b0;
      end else begin
         state    <= stateNext;
         tick     <= tickNext;
         bitIdx   <= bitIdxNext;
         shiftReg <= shiftNext;
         samp3    <= samp3Next;
         samp4    <= samp4Next;
         pushPend <= pushNow;
      end
   end

   uart_fifo2_m #(
      .WIDTH (8)
   ) u_fifo (
      .clk    (clk),
      .resetn (resetn),
      .wdata  (shiftReg),
      .push   (pushPend),
      .pop    (rd),
      .rdata  (q),
      .full   (fifoFull),
      .empty  (fifoEmpty)
   );

   assign rxvalid = ~fifoEmpty;

   // A push into a full FIFO is lost unless a pop frees space on the same
   // edge (rd with a full FIFO is always a real pop).
   assign ovfEvent = pushPend & fifoFull & ~rd;

   // Sticky error flags. A new error on the same edge as clrerr wins.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         ferr <= 1'b0;
         ovf  <= 1'b0;
      end else begin
         if (frameErr) begin
            ferr <= 1'b1;
         end else if (clrerr) begin
            ferr <= 1'b0;
         end
         if (ovfEvent) begin
            ovf <= 1'b1;
         end else if (clrerr) begin
            ovf <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_fifo_m.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_fifo_m
// Drives serial frames into uart_rx_fifo_m (RXINVERT=1, so the pin carries
// the inverted transmitter line) and checks received bytes through a
// scoreboard queue popped by an independent monitor process.
// ---------------------------------------------------------------------------
module tb_uart_rx_fifo_m;
   import uart_pkg::*;

   logic       clk     = 1'b0;
   logic       resetn  = 1'b0;
   logic       bitx8ce = 1'b0;
   logic       rxpin   = 1'b0;
   logic       rd      = 1'b0;
   logic       clrerr  = 1'b0;
   logic [7:0] q;
   logic       rxvalid;
   logic       ferr;
   logic       ovf;

   int         compareCount = 0;
   int         failCount    = 0;
   logic [7:0] expQ [$];
   bit         autoPop  = 1'b0;
   bit         forcePop = 1'b0;
   logic [1:0] ceDiv    = 2'd0;

   uart_rx_fifo_m #(
      .RXINVERT  (1'b1),
      .STOPCHECK (1'b1)
   ) dut (
      .clk     (clk),
      .resetn  (resetn),
      .bitx8ce (bitx8ce),
      .rxpin   (rxpin),
      .rd      (rd),
      .clrerr  (clrerr),
      .q       (q),
      .rxvalid (rxvalid),
      .ferr    (ferr),
      .ovf     (ovf)
   );

   // 100 MHz clock
   always #5 clk = ~clk;

   // 8x bit-rate enable: one clk high out of every four, changed on the
   // falling edge so it is stable at every rising edge
   always @(negedge clk) begin
      ceDiv   <= ceDiv + 2'd1;
      bitx8ce <= (ceDiv == 2'd3);
   end

   // One comparison: counts it and reports a mismatch
   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      compareCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Wait for n bitx8ce edges, then step just past the edge
   task automatic waitCe(input int n);
      repeat (n) begin
         do @(posedge clk); while (bitx8ce !== 1'b1);
      end
      #1;
   endtask

   // Send one 8N1 frame (pin is the inverse of the logical line). Optionally
   // hold rd on the FIFO push edge, or reset the DUT in the middle of data
   // bit abortBit (-1 = no abort).
   task automatic applyStimulus(input logic [7:0] data, input bit stopBit,
                                input bit popAtPush, input int abortBit);
      logic [9:0] frame;
      frame = {stopBit, data, 1'b0};
      waitCe(1);
      for (int i = 0; i < 10; i++) begin
         rxpin = ~frame[i];
         if (abortBit >= 0 && i == abortBit + 1) begin
            waitCe(4);
            resetn = 1'b0;
            repeat (3) @(posedge clk);
            #1;
            resetn = 1'b1;
            rxpin  = 1'b0;
            waitCe(16);
            return;
         end
         if (i == 9) begin
            waitCe(7);
            if (popAtPush) begin
               forcePop = 1'b1;
               @(posedge clk);
               #1;
               forcePop = 1'b0;
            end
            waitCe(1);
         end else begin
            waitCe(8);
         end
      end
      rxpin = 1'b0;
      waitCe(2);
   endtask

   // Bounded wait for the scoreboard to empty
   task automatic waitDrain();
      for (int budget = 0; budget < 2000 && expQ.size() != 0; budget++) begin
         @(posedge clk);
      end
      repeat (4) @(posedge clk);
      #1;
      checkOutput("queueDrained", 32'(expQ.size()), 32'd0);
   endtask

   // One-clock clrerr pulse, checked after it has taken effect
   task automatic pulseClr();
      @(negedge clk);
      clrerr = 1'b1;
      @(negedge clk);
      clrerr = 1'b0;
      @(posedge clk);
      #1;
   endtask

   // Monitor: whenever a byte is presented and a pop is wanted, compare it
   // with the scoreboard head and issue rd for the next rising edge
   initial begin
      logic [7:0] expByte;
      forever begin
         @(negedge clk);
         if (rxvalid === 1'b1 && (autoPop || forcePop)) begin
            compareCount++;
            if (expQ.size() == 0) begin
               failCount++;
               $display("[TB] FAIL unexpectedByte: got 0x%0h, expected none", q);
            end else begin
               expByte = expQ.pop_front();
               if (q !== expByte) begin
                  failCount++;
                  $display("[TB] FAIL rxByte: got 0x%0h, expected 0x%0h", q, expByte);
               end
            end
            rd = 1'b1;
         end else begin
            rd = forcePop;
         end
      end
   end

   // Global time limit
   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "[TB] timeout");
   end

   // Main directed sequence
   initial begin
      resetn = 1'b0;
      rxpin  = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      checkOutput("resetRxvalid", 32'(rxvalid), 32'd0);
      checkOutput("resetFerr", 32'(ferr), 32'd0);
      checkOutput("resetOvf", 32'(ovf), 32'd0);
      checkOutput("resetQ", 32'(q), 32'h00);
      checkOutput("resetState", 32'(dut.state), 32'(IDLE));
      resetn = 1'b1;

      $display("[TB] rd on empty FIFO");
      forcePop = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      forcePop = 1'b0;
      checkOutput("rdWhenEmpty", 32'(rxvalid), 32'd0);

      $display("[TB] loopback 41 4E");
      autoPop = 1'b1;
      expQ.push_back(8'h41);
      expQ.push_back(8'h4E);
      applyStimulus(8'h41, 1'b1, 1'b0, -1);
      applyStimulus(8'h4E, 1'b1, 1'b0, -1);
      waitDrain();
      checkOutput("loopFerr", 32'(ferr), 32'd0);
      checkOutput("loopOvf", 32'(ovf), 32'd0);

      $display("[TB] start glitch");
      waitCe(1);
      rxpin = 1'b1;
      waitCe(2);
      rxpin = 1'b0;
      waitCe(20);
      checkOutput("glitchRxvalid", 32'(rxvalid), 32'd0);
      checkOutput("glitchFerr", 32'(ferr), 32'd0);
      checkOutput("glitchState", 32'(dut.state), 32'(IDLE));

      $display("[TB] framing error then recovery");
      applyStimulus(8'h55, 1'b0, 1'b0, -1);
      checkOutput("frameFerr", 32'(ferr), 32'd1);
      checkOutput("frameRxvalid", 32'(rxvalid), 32'd0);
      expQ.push_back(8'hA5);
      applyStimulus(8'hA5, 1'b1, 1'b0, -1);
      waitDrain();
      checkOutput("ferrSticky", 32'(ferr), 32'd1);
      pulseClr();
      checkOutput("ferrCleared", 32'(ferr), 32'd0);

      $display("[TB] overrun");
      autoPop = 1'b0;
      expQ.push_back(8'h41);
      expQ.push_back(8'h4E);
      applyStimulus(8'h41, 1'b1, 1'b0, -1);
      applyStimulus(8'h4E, 1'b1, 1'b0, -1);
      applyStimulus(8'h33, 1'b1, 1'b0, -1);
      waitCe(4);
      checkOutput("ovfRxvalid", 32'(rxvalid), 32'd1);
      checkOutput("ovfHead", 32'(q), 32'h41);
      checkOutput("ovfSet", 32'(ovf), 32'd1);
      autoPop = 1'b1;
      waitDrain();
      checkOutput("ovfDrained", 32'(rxvalid), 32'd0);
      pulseClr();
      checkOutput("ovfCleared", 32'(ovf), 32'd0);

      $display("[TB] pop on push edge while full");
      autoPop = 1'b0;
      expQ.push_back(8'h41);
      expQ.push_back(8'h4E);
      expQ.push_back(8'h33);
      applyStimulus(8'h41, 1'b1, 1'b0, -1);
      applyStimulus(8'h4E, 1'b1, 1'b0, -1);
      applyStimulus(8'h33, 1'b1, 1'b1, -1);
      waitCe(2);
      checkOutput("simulOvf", 32'(ovf), 32'd0);
      checkOutput("simulHead", 32'(q), 32'h4E);
      autoPop = 1'b1;
      waitDrain();

      $display("[TB] reset mid-frame");
      applyStimulus(8'hC3, 1'b1, 1'b0, 4);
      expQ.push_back(8'h3C);
      applyStimulus(8'h3C, 1'b1, 1'b0, -1);
      waitDrain();
      checkOutput("abortFerr", 32'(ferr), 32'd0);
      checkOutput("abortOvf", 32'(ovf), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", compareCount, failCount);
      $finish;
   end

endmodule
